instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and fetch counter.
// Optional macro PC_ALIGN_CHECK_EN enables misaligned-branch detection and the HALT state.
//
// state | meaning
// IDLE  | waiting for start; pc held, IF/ID empty
// RUN   | fetching one word per edge unless stalled or redirected
// HALT  | misaligned branch seen; everything frozen until reset (PC_ALIGN_CHECK_EN only)
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count,
    output logic        fetch_fault
);

    // Byte-address window covered by the instruction memory.
    localparam logic [31:0] ADDR_MASK = 32'(IMEM_WORDS * 4 - 1);

`ifdef PC_ALIGN_CHECK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] instr_next, pc4_next, count_next;
    logic        valid_next;
    logic [31:0] pc_inc;
    logic [31:0] target;

    assign imem_addr = pc;
    assign pc_inc    = (pc + 32'd4) & ADDR_MASK;
    assign target    = branch_target & ADDR_MASK & ~32'd3;

`ifdef PC_ALIGN_CHECK_EN
    logic fault, fault_next;
    assign fetch_fault = fault;
`else
    assign fetch_fault = 1'b0;
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = if_id_instr;
        pc4_next   = if_id_pc4;
        valid_next = if_id_valid;
        count_next = fetch_count;
`ifdef PC_ALIGN_CHECK_EN
        fault_next = fault;
`endif
        case (state)
            IDLE: begin
                instr_next = 32'd0;
                valid_next = 1'b0;
                if (start) state_next = RUN;
            end
            RUN: begin
                if (branch_taken) begin
                    instr_next = 32'd0;
                    valid_next = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
                    if (branch_target[1:0] != 2'b00) begin
                        state_next = HALT;
                        fault_next = 1'b1;
                    end else begin
                        pc_next = target;
                    end
`else
                    pc_next = target;
`endif
                end else if (!stall) begin
                    instr_next = imem_data;
                    pc4_next   = pc_inc;
                    valid_next = 1'b1;
                    pc_next    = pc_inc;
                    count_next = fetch_count + 32'd1;
                end
            end
`ifdef PC_ALIGN_CHECK_EN
            HALT: ;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            if_id_instr <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            fetch_count <= 32'd0;
`ifdef PC_ALIGN_CHECK_EN
            fault       <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            if_id_instr <= instr_next;
            if_id_pc4   <= pc4_next;
            if_id_valid <= valid_next;
            fetch_count <= count_next;
`ifdef PC_ALIGN_CHECK_EN
            fault       <= fault_next;
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios then randomized traffic
// against a behavioural fetch model; honours PC_ALIGN_CHECK_EN when defined.
module tb_instr_fetch;

    localparam int          WORDS = 256;
    localparam int unsigned SPAN  = WORDS * 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic        fetch_fault;

    logic [31:0] mem [WORDS];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: 0 = idle, 1 = running, 2 = halted.
    int          m_mode;
    int unsigned m_pc, m_instr, m_pc4, m_count;
    bit          m_valid, m_fault;

    instr_fetch #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS)) dut (
        .clock(clock), .reset(reset), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .fetch_count(fetch_count), .fetch_fault(fetch_fault)
    );

    always #5 clock = ~clock;

    assign imem_data = mem[imem_addr[9:2]];

    function automatic logic [31:0] word_at(input int unsigned addr);
        return 32'hA5A5_0000 ^ (addr % SPAN);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit st, input bit sl, input bit br,
                              input int unsigned tgt);
        if (rst) begin
            m_mode = 0; m_pc = 0; m_instr = 0; m_pc4 = 0;
            m_valid = 0; m_count = 0; m_fault = 0;
        end else if (m_mode == 0) begin
            if (st) m_mode = 1;
        end else if (m_mode == 1) begin
            if (br) begin
                m_instr = 0;
                m_valid = 0;
`ifdef PC_ALIGN_CHECK_EN
                if (tgt % 4 != 0) begin
                    m_mode  = 2;
                    m_fault = 1;
                end else
                    m_pc = tgt % SPAN;
`else
                m_pc = (tgt - tgt % 4) % SPAN;
`endif
            end else if (!sl) begin
                m_instr = word_at(m_pc);
                m_pc    = (m_pc + 4) % SPAN;
                m_pc4   = m_pc;
                m_valid = 1;
                m_count = m_count + 1;
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit st, input bit sl, input bit br,
                       input logic [31:0] tgt);
        reset = rst; start = st; stall = sl; branch_taken = br; branch_target = tgt;
        @(posedge clock);
        model_step(rst, st, sl, br, tgt);
        #1;
        check("pc",    imem_addr,   m_pc);
        check("instr", if_id_instr, m_instr);
        check("pc4",   if_id_pc4,   m_pc4);
        check("valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        check("count", fetch_count, m_count);
        check("fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    endtask

    task automatic run_to(input int unsigned addr);
        for (int i = 0; i < WORDS && m_pc != addr; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = word_at(i * 4);
        m_mode = 0; m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_count = 0; m_fault = 0;

        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 32'h80);
        check("rst_pc", imem_addr, 32'h0);
        check("rst_valid", {31'd0, if_id_valid}, 32'd0);

        // Idle ignores branch and stall; start is a single-cycle pulse.
        cyc(0, 0, 0, 1, 32'h80);
        check("idle_pc", imem_addr, 32'h0);
        cyc(0, 1, 0, 0, 0);
        check("start_no_fetch", {31'd0, if_id_valid}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        check("first_valid", {31'd0, if_id_valid}, 32'd1);
        check("first_instr", if_id_instr, 32'hA5A5_0000);
        check("first_pc4", if_id_pc4, 32'd4);
        check("first_count", fetch_count, 32'd1);

        run_to(32'h10);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 0);
            check("stall_pc", imem_addr, 32'h10);
            check("stall_count", fetch_count, 32'd4);
        end
        cyc(0, 0, 0, 0, 0);
        check("resume_instr", if_id_instr, 32'hA5A5_0010);
        check("resume_count", fetch_count, 32'd5);

        cyc(0, 0, 1, 1, 32'h40);
        check("br_stall_pc", imem_addr, 32'h40);
        check("br_stall_instr", if_id_instr, 32'h0);
        cyc(0, 0, 0, 0, 0);
        check("br_fetch_instr", if_id_instr, 32'hA5A5_0040);
        check("br_fetch_pc4", if_id_pc4, 32'h44);

        cyc(0, 0, 0, 1, 32'h3FC);
        cyc(0, 0, 0, 0, 0);
        check("wrap_pc", imem_addr, 32'h0);
        check("wrap_pc4", if_id_pc4, 32'h0);
        check("wrap_instr", if_id_instr, 32'hA5A5_03FC);

        cyc(0, 0, 0, 1, 32'h42);
`ifdef PC_ALIGN_CHECK_EN
        check("mis_fault", {31'd0, fetch_fault}, 32'd1);
        check("mis_pc", imem_addr, 32'h0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h80);
        check("halt_pc", imem_addr, 32'h0);
        check("halt_valid", {31'd0, if_id_valid}, 32'd0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
`else
        check("mis_pc", imem_addr, 32'h40);
        check("mis_fault", {31'd0, fetch_fault}, 32'd0);
`endif
        check("mis_valid", {31'd0, if_id_valid}, 32'd0);

        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 32'h80);
        check("midrun_rst_pc", imem_addr, 32'h0);
        check("midrun_rst_count", fetch_count, 32'h0);
        cyc(0, 0, 0, 0, 0);
        check("post_rst_idle", imem_addr, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            bit          r, s, sl, b;
            logic [31:0] t;
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 30);
            sl = ($urandom_range(0, 99) < 25);
            b  = ($urandom_range(0, 99) < 10);
            case ($urandom_range(0, 3))
                0:       t = 32'h3FC;
                1:       t = $urandom;
                default: t = {20'd0, 12'($urandom_range(0, 4095)) & 12'hFFC};
            endcase
            if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom_range(1, 3));
            cyc(r, s, sl, b, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
